// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexes shadowed BCD digits onto a shared active-low cathode bus with PWM dimming
module seven_seg_scan #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  CLK100MHZ,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   BCD_in,
  input  logic [DIGITS-1:0]     DP_in,
  input  logic [DIGITS-1:0]     Blank_in,
  input  logic [7:0]            pwm_in,
  output logic [7:0]            SevenSegment,
  output logic [7:0]            SegmentDrivers,
  output logic                  FrameStart
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [6:0] CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };
  logic [RW-1:0]       refresh_cnt_q, refresh_cnt_d;
  logic [2:0]          digit_idx_q, digit_idx_d;
  logic [7:0]          pwm_cnt_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   dp_q, blank_q;
  logic [7:0]          seg_q, seg_d, an_q, an_d;
  logic                frame_q;
  logic                wrap, last_digit, latch, dark, dp_cur, blank_cur;
  logic [3:0]          digit;
  always_comb begin
    wrap          = refresh_cnt_q == RW'(REFRESH_DIV - 1);
    last_digit    = digit_idx_q == 3'(DIGITS - 1);
    latch         = wrap && last_digit;
    refresh_cnt_d = wrap ? '0 : refresh_cnt_q + 1'b1;
    digit_idx_d   = !wrap ? digit_idx_q : last_digit ? 3'd0 : digit_idx_q + 3'd1;
    digit         = 4'(bcd_q >> {digit_idx_q, 2'b00});
    dp_cur        = 1'(dp_q >> digit_idx_q);
    blank_cur     = 1'(blank_q >> digit_idx_q);
    // blanking guard at slot start keeps the previous digit from ghosting
    dark          = (32'(refresh_cnt_q) < BLANK_CYCLES) || blank_cur || !(pwm_cnt_q < pwm_in);
    seg_d         = dark ? 8'hFF : {~dp_cur, CODES[digit]};
    an_d          = dark ? 8'hFF : ~(8'd1 << digit_idx_q);
  end
  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
      pwm_cnt_q     <= '0;
      bcd_q         <= '0;
      dp_q          <= '0;
      blank_q       <= '1;
      seg_q         <= 8'hFF;
      an_q          <= 8'hFF;
      frame_q       <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
      pwm_cnt_q     <= pwm_cnt_q + 8'd1;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_q       <= latch;
      if (latch) begin
        bcd_q   <= BCD_in;
        dp_q    <= DP_in;
        blank_q <= Blank_in;
      end
    end
  end
  assign SevenSegment   = seg_q;
  assign SegmentDrivers = an_q;
  assign FrameStart     = frame_q;
endmodule
